tdm_demux2: RTL and testbench

- Receive-side counterpart of the team's 2:1 multiplexing path: it takes a single-bit, time-division-multiplexed stream in which two channels alternate beat-by-beat, and recovers the two parallel words.
- A frame-sync marker locks the block to frame boundaries.
- Bits are deserialized per channel, MSB first, and both words are presented together with a one-cycle valid pulse.
- Sits after the serial link or mux stage, feeding downstream parallel logic.

---
 rtl/tdm_demux2_pkg.sv | 14 +
 rtl/tdm_demux2_sipo_shift.sv | 37 +++
 rtl/tdm_demux2.sv | 133 +++++++++++++
 tb/tb_tdm_demux2.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux2_pkg.sv
// Shared types and helpers for the two-channel TDM deserializer.
package tdm_demux2_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Beat counter width for a frame of 2*width beats.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/tdm_demux2_sipo_shift.sv
// Serial-in parallel-out shift register; the first bit shifted in ends up as the MSB.
module sipo_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] base;

  // clr with shift starts a fresh word holding only the current bit
  always_comb begin
    base = clr_i ? '0 : q_q;
    q_d  = base;
    if (shift_i) begin
      q_d = {base[WIDTH-2:0], din_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Word including the current beat, so the final bit can be captured on the same edge.
  assign word_o = shift_i ? {q_q[WIDTH-2:0], din_i} : q_q;

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM deserializer: locks to fsync and presents both channel words with a valid pulse.
//
// state  | meaning
// HUNT   | not aligned, discarding beats until a beat with fsync
// LOCKED | aligned, cnt tracks the beat position within the frame
module tdm_demux2
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             fsync,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic             dout_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int FRAME_BEATS = 2 * WIDTH;
  localparam int CW          = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BEATS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ch0_q, ch0_d;
  logic [WIDTH-1:0] ch1_q, ch1_d;
  logic             dout_valid_q, dout_valid_d;
  logic             sync_err_q, sync_err_d;

  logic             sh_clr;
  logic             sh0_en;
  logic             sh1_en;
  logic [WIDTH-1:0] word0;
  logic [WIDTH-1:0] word1;

  sipo_shift #(.WIDTH(WIDTH)) u_sipo_ch0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (sh_clr),
    .shift_i (sh0_en),
    .din_i   (din),
    .word_o  (word0)
  );

  sipo_shift #(.WIDTH(WIDTH)) u_sipo_ch1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (sh_clr),
    .shift_i (sh1_en),
    .din_i   (din),
    .word_o  (word1)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch0_d        = ch0_q;
    ch1_d        = ch1_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    sh_clr       = 1'b0;
    sh0_en       = 1'b0;
    sh1_en       = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (fsync) begin
            state_d = LOCKED;
            cnt_d   = CNT_ONE;
            sh_clr  = 1'b1;
            sh0_en  = 1'b1;
          end
        end
        LOCKED: begin
          if (fsync) begin
            // An fsync anywhere but cnt=0 abandons the partial frame and restarts.
            sync_err_d = (cnt_q != '0);
            cnt_d      = CNT_ONE;
            sh_clr     = 1'b1;
            sh0_en     = 1'b1;
          end else if (cnt_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            sh_clr     = 1'b1;
          end else begin
            sh0_en = ~cnt_q[0];
            sh1_en = cnt_q[0];
            if (cnt_q == LAST_BEAT) begin
              cnt_d        = '0;
              ch0_d        = word0;
              ch1_d        = word1;
              dout_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      ch0_q        <= '0;
      ch1_q        <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch0_q        <= ch0_d;
      ch1_q        <= ch1_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign ch0_data   = ch0_q;
  assign ch1_data   = ch1_q;
  assign dout_valid = dout_valid_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2 at WIDTH=8 with hand-computed expected words.
module tb_tdm_demux2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       fsync = 1'b0;
  logic [7:0] ch0_data;
  logic [7:0] ch1_data;
  logic       dout_valid;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int ecount = 0;
  int v0;
  int e0;

  tdm_demux2 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .fsync      (fsync),
    .ch0_data   (ch0_data),
    .ch1_data   (ch1_data),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid) vcount++;
    if (sync_err) ecount++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic b, input logic fs);
    din       = b;
    fsync     = fs;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    fsync     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Beats first..last of a frame carrying a/b; fsync on the first beat sent when fs is set.
  task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input logic fs,
                           input int first, input int last, input int stall_after);
    logic bitv;
    for (int i = first; i <= last; i++) begin
      bitv = (i % 2 == 0) ? a[7 - i/2] : b[7 - i/2];
      beat(bitv, fs && (i == first));
      if (i == stall_after) idle(3);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] a, input logic [7:0] b);
    chk({tag, "_dv"},     16'(dout_valid), 16'd1);
    chk({tag, "_ch0"},    16'(ch0_data),   16'(a));
    chk({tag, "_ch1"},    16'(ch1_data),   16'(b));
    chk({tag, "_locked"}, 16'(locked),     16'd1);
    chk({tag, "_serr"},   16'(sync_err),   16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ch0",    16'(ch0_data),   16'h00);
    chk("rst_ch1",    16'(ch1_data),   16'h00);
    chk("rst_dv",     16'(dout_valid), 16'd0);
    chk("rst_locked", 16'(locked),     16'd0);
    chk("rst_serr",   16'(sync_err),   16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // HUNT discards beats without fsync
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    chk("hunt_locked", 16'(locked),   16'd0);
    chk("hunt_vcount", 16'(vcount),   16'd0);
    chk("hunt_ch0",    16'(ch0_data), 16'h00);
    send_bits(8'hC3, 8'h0F, 1'b1, 0, 15, -1);
    check_frame("c3", 8'hC3, 8'h0F);
    idle(1);
    chk("c3_dv_pulse", 16'(dout_valid), 16'd0);

    // basic frame
    send_bits(8'hA5, 8'h3C, 1'b1, 0, 15, -1);
    check_frame("a5", 8'hA5, 8'h3C);
    idle(1);

    // back-to-back frames with a 3-cycle stall inside each
    v0 = vcount;
    send_bits(8'h12, 8'h34, 1'b1, 0, 15, 5);
    check_frame("f12", 8'h12, 8'h34);
    send_bits(8'hFE, 8'h01, 1'b1, 0, 15, 10);
    check_frame("ffe", 8'hFE, 8'h01);
    idle(2);
    chk("b2b_pulses", 16'(vcount - v0), 16'd2);

    // missing sync at frame start
    e0 = ecount;
    beat(1'b1, 1'b0);
    chk("miss_serr",   16'(sync_err),   16'd1);
    chk("miss_locked", 16'(locked),     16'd0);
    chk("miss_dv",     16'(dout_valid), 16'd0);
    chk("miss_ch0",    16'(ch0_data),   16'hFE);
    chk("miss_ch1",    16'(ch1_data),   16'h01);
    idle(1);
    chk("miss_serr_pulse", 16'(sync_err),     16'd0);
    chk("miss_ecount",     16'(ecount - e0),  16'd1);
    send_bits(8'h55, 8'hAA, 1'b1, 0, 15, -1);
    check_frame("f55", 8'h55, 8'hAA);

    // early sync at cnt=6
    send_bits(8'hF0, 8'h0F, 1'b1, 0, 5, -1);
    chk("part_serr",   16'(sync_err), 16'd0);
    chk("part_locked", 16'(locked),   16'd1);
    send_bits(8'h80, 8'h7F, 1'b1, 0, 0, -1);
    chk("early_serr",   16'(sync_err), 16'd1);
    chk("early_locked", 16'(locked),   16'd1);
    send_bits(8'h80, 8'h7F, 1'b0, 1, 15, -1);
    check_frame("f80", 8'h80, 8'h7F);
    chk("early_ecount", 16'(ecount - e0), 16'd2);

    // asynchronous reset between edges at cnt=9
    send_bits(8'h99, 8'h66, 1'b1, 0, 8, -1);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ch0",    16'(ch0_data),   16'h00);
    chk("arst_ch1",    16'(ch1_data),   16'h00);
    chk("arst_dv",     16'(dout_valid), 16'd0);
    chk("arst_locked", 16'(locked),     16'd0);
    chk("arst_serr",   16'(sync_err),   16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_bits(8'h11, 8'h22, 1'b1, 0, 15, -1);
    check_frame("f11", 8'h11, 8'h22);
    idle(2);
    chk("total_pulses", 16'(vcount), 16'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
